// File: rtl/joy_db15_tx.sv
// joy_db15_tx: emulates the 74HC165 chain of a DB15 arcade joystick adapter.
// The reader drives JOY_LOAD (active-low load) and JOY_CLK (shift clock)
// asynchronously. This module answers with the two 12-bit player words as
// active-low bits on JOY_DATA. The order is joystick1[0..11], then
// joystick2[0..11].
// Optional build macro: JOY_DB15_TX_GLITCH_FILTER_EN adds a 3-sample
// stability filter behind each synchronizer. That filter adds 2 cycles of
// latency and rejects pulses of 2 cycles or less.
`timescale 1ns/1ps

module joy_db15_tx #(
   parameter logic        FILL_BIT    = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [11:0] joystick1,
   input  logic [11:0] joystick2,
   input  logic        JOY_CLK,
   input  logic        JOY_LOAD,
   output logic        JOY_DATA,
   output logic [4:0]  bit_cnt,
   output logic        frame_done
);

   localparam logic [4:0] FRAME_BITS = 5'd24;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] load_sync;
   logic                   clk_lvl;
   logic                   load_lvl;
   logic                   clk_hist;
   logic                   load_hist;
   logic                   clk_rise;
   logic                   load_rise;
   logic                   armed;
   logic [23:0]            sreg;
   logic [23:0]            load_word;

   // Synchronizer chains for the reader's asynchronous strobes; idle high.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         load_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], JOY_CLK};
         load_sync <= {load_sync[SYNC_STAGES-2:0], JOY_LOAD};
      end
   end

`ifdef JOY_DB15_TX_GLITCH_FILTER_EN
   logic [1:0] clk_taps;
   logic [1:0] load_taps;
   logic       clk_filt;
   logic       load_filt;

   // Sample history and held filtered level for each synchronized strobe.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_taps  <= '1;
         load_taps <= '1;
         clk_filt  <= 1'b1;
         load_filt <= 1'b1;
      end else begin
         clk_taps  <= {clk_taps[0], clk_sync[SYNC_STAGES-1]};
         load_taps <= {load_taps[0], load_sync[SYNC_STAGES-1]};
         clk_filt  <= clk_lvl;
         load_filt <= load_lvl;
      end
   end

   // The level follows the input only once three consecutive samples agree.
   // The new level is used in the same cycle, so the filter costs 2 cycles.
   always_comb begin
      clk_lvl  = clk_filt;
      load_lvl = load_filt;
      if (clk_sync[SYNC_STAGES-1] == clk_taps[0] && clk_sync[SYNC_STAGES-1] == clk_taps[1])
         clk_lvl = clk_sync[SYNC_STAGES-1];
      if (load_sync[SYNC_STAGES-1] == load_taps[0] && load_sync[SYNC_STAGES-1] == load_taps[1])
         load_lvl = load_sync[SYNC_STAGES-1];
   end
`else
   // Unfiltered: the last synchronizer stage is the working level.
   always_comb begin
      clk_lvl  = clk_sync[SYNC_STAGES-1];
      load_lvl = load_sync[SYNC_STAGES-1];
   end
`endif

   // History flops for edge detection; idle high, so reset release never
   // looks like a rising edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_hist  <= 1'b1;
         load_hist <= 1'b1;
      end else begin
         clk_hist  <= clk_lvl;
         load_hist <= load_lvl;
      end
   end

   // Rising-edge strobes and the active-low parallel word. Each player's
   // bit 0 sits at the top of its field, so it is shifted out first.
   always_comb begin
      clk_rise  = clk_lvl & ~clk_hist;
      load_rise = load_lvl & ~load_hist;
      load_word = '1;
      for (int unsigned i = 0; i < 12; i++) begin
         load_word[23-i] = ~joystick1[i];
         load_word[11-i] = ~joystick2[i];
      end
   end

   // Transparent load while LOAD is low. Otherwise shift on CLK rises.
   // frame_done fires once per load.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sreg       <= '1;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
         armed      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!load_lvl) begin
            sreg    <= load_word;
            bit_cnt <= '0;
            armed   <= 1'b0;
         end else begin
            if (load_rise)
               armed <= 1'b1;
            if (clk_rise) begin
               sreg <= {sreg[22:0], FILL_BIT};
               if (bit_cnt != FRAME_BITS)
                  bit_cnt <= bit_cnt + 5'd1;
               if (armed && bit_cnt == FRAME_BITS - 5'd1) begin
                  frame_done <= 1'b1;
                  armed      <= 1'b0;
               end
            end
         end
      end
   end

   // Serial output comes straight from the register MSB.
   always_comb JOY_DATA = sreg[23];

endmodule
